mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle sequencer for the LEGv8-subset core.
- Takes the 4-bit opcode from the instruction decoder and ALU/compare status.
- Drives PC, instruction register, register file, memory and multiplier enables state by state.
- Sits between the instruction decoder and the shared single-port memory and datapath; the memory carries both instruction fetches and data accesses.

Parameters:
- MUL_TIMEOUT, 32: maximum cycles waited for mul_done before declaring a fault.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high.
- opcode, in, 4: decoder opcode. Encoding: ADDI=0, ADDS=1, BLT=2, B=3, CBZ=4, LDUR=5, LSL=6, LSR=7, MUL=8, STUR=9, SUBS=10, INV=11; 12–15 are treated as INV.
- zero, in, 1: register-operand-is-zero, for CBZ.
- flag_n, in, 1: stored N flag.
- flag_v, in, 1: stored V flag.
- mem_ready, in, 1: memory completion; sampled only while mem_req=1.
- mul_done, in, 1: multiplier result valid.
- mem_req, out, 1: memory request.
- mem_we, out, 1: memory write, for STUR.
- addr_sel, out, 1: memory address source; 0=PC, 1=ALU result.
- ir_we, out, 1: load instruction register.
- mdr_we, out, 1: load memory data register.
- alu_b_sel, out, 2: ALU B operand; 0=reg rm, 1=imm12, 2=imm9, 3=shamt.
- flags_we, out, 1: update NZCV flags.
- mul_start, out, 1: one-cycle multiplier start pulse.
- reg_we, out, 1: register-file write.
- wb_sel, out, 2: write-back source; 0=ALU, 1=MDR, 2=MUL.
- pc_we, out, 1: PC update.
- pc_src, out, 1: PC source; 0=PC+4, 1=branch target.
- halted, out, 1: fault-halt status.
- fault, out, 2: fault code; 0=none, 1=illegal opcode, 2=MUL timeout.
- retired, out, CNT_W: retired-instruction counter.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to FETCH.
  - Every output is 0, including retired, halted and fault.
  - Reset mid-access drops mem_req on that same edge; an outstanding mem_ready is ignored.
- Outputs are Moore-decoded from the state, except the signals noted as qualified by mem_ready or conditions below.
- FETCH: mem_req=1, addr_sel=0.
  - Hold until mem_ready=1.
  - In that cycle ir_we=1; next state DECODE.
- DECODE: one cycle, no enables. Next state by opcode:
  - B, BLT, CBZ go to BRANCH.
  - MUL goes to MUL_WAIT, with mul_start=1 in this DECODE cycle only.
  - INV or 12–15 go to HALT with fault=1.
  - All others go to EXEC.
- EXEC: one cycle. alu_b_sel depends on opcode:
  - ADDI: 1.
  - LDUR, STUR: 2.
  - LSL, LSR: 3.
  - ADDS, SUBS: 0, with flags_we=1.
  - Next state: LDUR and STUR go to MEM; all others go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 only for STUR. Hold until mem_ready. In the mem_ready cycle:
  - LDUR: mdr_we=1; next state WB.
  - STUR: pc_we=1, pc_src=0, retire; next state FETCH.
- WB: one cycle; next state FETCH.
  - reg_we=1; wb_sel is 1 for LDUR, 2 for MUL, else 0.
  - pc_we=1, pc_src=0, retire.
  - ADDS and SUBS also write rd.
- BRANCH: one cycle; next state FETCH.
  - Taken when: B always; CBZ if zero=1; BLT if flag_n != flag_v.
  - pc_we=1, pc_src=taken, retire.
- MUL_WAIT: internal counter cleared on entry, incremented each cycle.
  - mul_done=1 goes to WB; mul_done is checked before the timeout.
  - Counter reaching MUL_TIMEOUT-1 without mul_done goes to HALT with fault=2.
- HALT: all enables 0, halted=1, fault held. Leaves only on reset.
- Opcode is sampled from the decoder continuously. The IR is stable from DECODE until the next FETCH completes, so opcode must not change mid-instruction.
- retire means retired increments by 1 on that edge; it wraps modulo 2^CNT_W.
- mem_ready while mem_req=0 is ignored.
- At most one of ir_we, mdr_we, reg_we is asserted per cycle.
- Latency with zero-wait memory (mem_ready same cycle):
  - ALU ops: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - Branches: 3 cycles.
  - MUL: 3+N cycles.

Test Plan:
- Reset, then ADDI with mem_ready always 1:
  - Outputs 0 during reset.
  - ir_we at cycle 0, alu_b_sel=1 at cycle 2, reg_we=1/pc_we=1 at cycle 3.
  - retired=1 after cycle 3.
- LDUR with mem_ready delayed 3 cycles in both FETCH and MEM:
  - mem_req held high with addr_sel 0 then 1.
  - mdr_we only in the ready cycle; wb_sel=1 in WB.
  - 11 cycles total.
- Branches, one instruction each:
  - CBZ with zero=0: pc_src=0.
  - CBZ with zero=1: pc_src=1.
  - BLT with flag_n=1, flag_v=0: pc_src=1.
  - BLT with flag_n=1, flag_v=1: pc_src=0.
  - B: pc_src=1.
  - Each takes 3 cycles.
- MUL with mul_done after 5 cycles:
  - mul_start a single pulse.
  - WB with wb_sel=2.
- MUL with mul_done never asserted and MUL_TIMEOUT=8: halted=1, fault=2, no further mem_req.
- opcode=11 (INV): halt after DECODE with fault=1.
- Reset asserted mid-MEM of STUR: mem_req and mem_we are 0 next cycle; restart in FETCH; retired unchanged at 0.

Source files
------------

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
//
// Multicycle sequencer for the LEGv8-subset core. It steps each instruction
// through FETCH / DECODE / EXEC / MEM / WB / BRANCH / MUL_WAIT. On each step it
// enables the PC, the instruction register, the register file, the shared
// single-port memory and the multiplier. Illegal opcodes and multiplier
// timeouts park the sequencer in HALT until reset.
//
// Ports
//   i_clk          clock; all state changes on the rising edge
//   i_reset        synchronous, active-high reset
//   i_opcode[3:0]  decoder opcode (ADDI=0 .. INV=11, 12-15 treated as INV)
//   i_zero         register operand is zero (CBZ condition)
//   i_flag_n/v     stored N and V flags (BLT condition)
//   i_mem_ready    memory completion, only looked at while o_mem_req=1
//   i_mul_done     multiplier result valid
//   o_mem_req      memory request
//   o_mem_we       memory write (STUR)
//   o_addr_sel     memory address source: 0=PC, 1=ALU result
//   o_ir_we        load instruction register
//   o_mdr_we       load memory data register
//   o_alu_b_sel    ALU B source: 0=rm, 1=imm12, 2=imm9, 3=shamt
//   o_flags_we     update NZCV
//   o_mul_start    one-cycle multiplier start pulse
//   o_reg_we       register-file write
//   o_wb_sel       write-back source: 0=ALU, 1=MDR, 2=MUL
//   o_pc_we        PC update (also marks instruction retirement)
//   o_pc_src       PC source: 0=PC+4, 1=branch target
//   o_halted       sequencer is parked in HALT
//   o_fault[1:0]   0=none, 1=illegal opcode, 2=MUL timeout
//   o_retired      retired-instruction counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mc_control #(
    parameter int MUL_TIMEOUT = 32,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [3:0]       i_opcode,
    input  logic             i_zero,
    input  logic             i_flag_n,
    input  logic             i_flag_v,
    input  logic             i_mem_ready,
    input  logic             i_mul_done,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_addr_sel,
    output logic             o_ir_we,
    output logic             o_mdr_we,
    output logic [1:0]       o_alu_b_sel,
    output logic             o_flags_we,
    output logic             o_mul_start,
    output logic             o_reg_we,
    output logic [1:0]       o_wb_sel,
    output logic             o_pc_we,
    output logic             o_pc_src,
    output logic             o_halted,
    output logic [1:0]       o_fault,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_ADDS = 4'd1,
        OP_BLT  = 4'd2,
        OP_B    = 4'd3,
        OP_CBZ  = 4'd4,
        OP_LDUR = 4'd5,
        OP_LSL  = 4'd6,
        OP_LSR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_STUR = 4'd9,
        OP_SUBS = 4'd10,
        OP_INV  = 4'd11
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_MUL_WAIT,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        F_NONE        = 2'd0,
        F_ILLEGAL     = 2'd1,
        F_MUL_TIMEOUT = 2'd2
    } fault_e;

    // Wide enough to hold MUL_TIMEOUT-1 for any MUL_TIMEOUT >= 1.
    localparam int             MCW      = $clog2(MUL_TIMEOUT) + 1;
    localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_TIMEOUT - 1);

    state_e           r_state;
    fault_e           r_fault;
    logic [MCW-1:0]   r_mul_cnt;
    logic [CNT_W-1:0] r_retired;

    logic             w_taken;
    logic             w_retire;

    // Branch condition, only consumed in BRANCH.
    always_comb begin
        case (i_opcode)
            OP_B:    w_taken = 1'b1;
            OP_CBZ:  w_taken = i_zero;
            OP_BLT:  w_taken = i_flag_n ^ i_flag_v;
            default: w_taken = 1'b0;
        endcase
    end

    // Every PC update ends an instruction, so it doubles as the retire strobe.
    assign w_retire = o_pc_we;

    // Output decode from the registered state, with the mem_ready / opcode /
    // condition qualifications. While reset is held every output reads 0,
    // which also drops an in-flight memory request immediately.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_addr_sel  = 1'b0;
        o_ir_we     = 1'b0;
        o_mdr_we    = 1'b0;
        o_alu_b_sel = 2'd0;
        o_flags_we  = 1'b0;
        o_mul_start = 1'b0;
        o_reg_we    = 1'b0;
        o_wb_sel    = 2'd0;
        o_pc_we     = 1'b0;
        o_pc_src    = 1'b0;
        o_halted    = 1'b0;
        o_fault     = 2'd0;
        o_retired   = '0;

        if (!i_reset) begin
            o_fault   = r_fault;
            o_retired = r_retired;
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    o_ir_we   = i_mem_ready;
                end
                S_DECODE: begin
                    o_mul_start = (i_opcode == OP_MUL);
                end
                S_EXEC: begin
                    case (i_opcode)
                        OP_ADDI:          o_alu_b_sel = 2'd1;
                        OP_LDUR, OP_STUR: o_alu_b_sel = 2'd2;
                        OP_LSL, OP_LSR:   o_alu_b_sel = 2'd3;
                        OP_ADDS, OP_SUBS: o_flags_we  = 1'b1;
                        default:          o_alu_b_sel = 2'd0;
                    endcase
                end
                S_MEM: begin
                    o_mem_req  = 1'b1;
                    o_addr_sel = 1'b1;
                    o_mem_we   = (i_opcode == OP_STUR);
                    if (i_mem_ready) begin
                        if (i_opcode == OP_STUR) begin
                            o_pc_we = 1'b1;
                        end else begin
                            o_mdr_we = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    o_reg_we = 1'b1;
                    o_pc_we  = 1'b1;
                    case (i_opcode)
                        OP_LDUR: o_wb_sel = 2'd1;
                        OP_MUL:  o_wb_sel = 2'd2;
                        default: o_wb_sel = 2'd0;
                    endcase
                end
                S_BRANCH: begin
                    o_pc_we  = 1'b1;
                    o_pc_src = w_taken;
                end
                S_MUL_WAIT: begin
                    // Datapath idle while the multiplier runs.
                end
                S_HALT: begin
                    o_halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // State, fault, multiplier watchdog and retire counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state   <= S_FETCH;
            r_fault   <= F_NONE;
            r_mul_cnt <= '0;
            r_retired <= '0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (i_opcode)
                        OP_B, OP_BLT, OP_CBZ: r_state <= S_BRANCH;
                        OP_MUL: begin
                            r_state   <= S_MUL_WAIT;
                            r_mul_cnt <= '0;
                        end
                        OP_ADDI, OP_ADDS, OP_LDUR, OP_LSL,
                        OP_LSR, OP_STUR, OP_SUBS: r_state <= S_EXEC;
                        default: begin
                            r_state <= S_HALT;
                            r_fault <= F_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC: begin
                    if (i_opcode == OP_LDUR || i_opcode == OP_STUR) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        r_state <= (i_opcode == OP_LDUR) ? S_WB : S_FETCH;
                    end
                end
                S_WB, S_BRANCH: begin
                    r_state <= S_FETCH;
                end
                S_MUL_WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (i_mul_done) begin
                        r_state <= S_WB;
                    end else if (r_mul_cnt == MUL_LAST) begin
                        r_state <= S_HALT;
                        r_fault <= F_MUL_TIMEOUT;
                    end else begin
                        r_mul_cnt <= r_mul_cnt + MCW'(1);
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
//
// Cycle-by-cycle vector table for mc_control. Each row holds the inputs
// applied during one clock cycle together with the outputs expected in that
// cycle. Rows are driven just after the rising edge, and the expected record
// is queued at that point. The queue is popped and compared against the DUT
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_mc_control;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic             mem_req;
        logic             mem_we;
        logic             addr_sel;
        logic             ir_we;
        logic             mdr_we;
        logic [1:0]       alu_b_sel;
        logic             flags_we;
        logic             mul_start;
        logic             reg_we;
        logic [1:0]       wb_sel;
        logic             pc_we;
        logic             pc_src;
        logic             halted;
        logic [1:0]       fault;
        logic [CNT_W-1:0] retired;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] op;
        logic       z;
        logic       n;
        logic       v;
        logic       rdy;
        logic       done;
        outs_t      exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       opcode;
    logic             zero, flag_n, flag_v, mem_ready, mul_done;
    logic             mem_req, mem_we, addr_sel, ir_we, mdr_we;
    logic [1:0]       alu_b_sel;
    logic             flags_we, mul_start, reg_we;
    logic [1:0]       wb_sel;
    logic             pc_we, pc_src, halted;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;

    mc_control #(.MUL_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_opcode    (opcode),
        .i_zero      (zero),
        .i_flag_n    (flag_n),
        .i_flag_v    (flag_v),
        .i_mem_ready (mem_ready),
        .i_mul_done  (mul_done),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_addr_sel  (addr_sel),
        .o_ir_we     (ir_we),
        .o_mdr_we    (mdr_we),
        .o_alu_b_sel (alu_b_sel),
        .o_flags_we  (flags_we),
        .o_mul_start (mul_start),
        .o_reg_we    (reg_we),
        .o_wb_sel    (wb_sel),
        .o_pc_we     (pc_we),
        .o_pc_src    (pc_src),
        .o_halted    (halted),
        .o_fault     (fault),
        .o_retired   (retired)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];
    outs_t sb[$];

    // Current table inputs; add() snapshots them into a new row.
    logic       t_rst, t_z, t_n, t_v, t_rdy, t_done;
    logic [3:0] t_op;

    task automatic add(input string nm, input outs_t e);
        vec_t r;
        r.name = nm;  r.rst = t_rst; r.op = t_op; r.z = t_z; r.n = t_n;
        r.v = t_v;    r.rdy = t_rdy; r.done = t_done; r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic check(input string nm, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Expected-output builders, one per kind of cycle.
    function automatic outs_t e_zero();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t e_fetch(input logic rdy, input int rt);
        outs_t o = '0;
        o.mem_req = 1'b1; o.ir_we = rdy; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_dec(input logic mul, input int rt);
        outs_t o = '0;
        o.mul_start = mul; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_exec(input logic [1:0] bsel, input logic fl, input int rt);
        outs_t o = '0;
        o.alu_b_sel = bsel; o.flags_we = fl; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_mem(input logic st, input logic rdy, input int rt);
        outs_t o = '0;
        o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = st;
        o.mdr_we  = rdy & ~st; o.pc_we = rdy & st; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_wb(input logic [1:0] wsel, input int rt);
        outs_t o = '0;
        o.reg_we = 1'b1; o.wb_sel = wsel; o.pc_we = 1'b1; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_br(input logic taken, input int rt);
        outs_t o = '0;
        o.pc_we = 1'b1; o.pc_src = taken; o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_idle(input int rt);
        outs_t o = '0;
        o.retired = CNT_W'(rt);
        return o;
    endfunction
    function automatic outs_t e_halt(input logic [1:0] f, input int rt);
        outs_t o = '0;
        o.halted = 1'b1; o.fault = f; o.retired = CNT_W'(rt);
        return o;
    endfunction

    task automatic branch(input string nm, input logic [3:0] op, input logic z,
                          input logic n, input logic v, input logic taken, input int rt);
        t_op = op; t_z = z; t_n = n; t_v = v;
        add({nm, "_fetch"}, e_fetch(1'b1, rt));
        add({nm, "_dec"},   e_dec(1'b0, rt));
        add({nm, "_br"},    e_br(taken, rt));
    endtask

    initial begin
        outs_t got, exp;

        reset = 1'b1; opcode = 4'd0; zero = 1'b0; flag_n = 1'b0; flag_v = 1'b0;
        mem_ready = 1'b0; mul_done = 1'b0;

        // ---------------- vector table ----------------
        t_rst = 1'b1; t_op = 4'd0; t_z = 1'b0; t_n = 1'b0; t_v = 1'b0;
        t_rdy = 1'b1; t_done = 1'b0;
        add("reset0", e_zero());
        add("reset1", e_zero());

        // ADDI, zero-wait memory: 4 cycles, retire in WB.
        t_rst = 1'b0; t_op = 4'd0;
        add("addi_fetch", e_fetch(1'b1, 0));
        add("addi_dec",   e_dec(1'b0, 0));
        add("addi_exec",  e_exec(2'd1, 1'b0, 0));
        add("addi_wb",    e_wb(2'd0, 0));

        // LDUR, 3 wait cycles in FETCH and in MEM: 11 cycles.
        t_op = 4'd5; t_rdy = 1'b0;
        for (int i = 0; i < 3; i++) add("ldur_fetch_wait", e_fetch(1'b0, 1));
        t_rdy = 1'b1;
        add("ldur_fetch_rdy", e_fetch(1'b1, 1));
        add("ldur_dec",       e_dec(1'b0, 1));   // mem_ready high but no request
        add("ldur_exec",      e_exec(2'd2, 1'b0, 1));
        t_rdy = 1'b0;
        for (int i = 0; i < 3; i++) add("ldur_mem_wait", e_mem(1'b0, 1'b0, 1));
        t_rdy = 1'b1;
        add("ldur_mem_rdy", e_mem(1'b0, 1'b1, 1));
        add("ldur_wb",      e_wb(2'd1, 1));

        // Branches, 3 cycles each.
        branch("cbz_nz",  4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        branch("cbz_z",   4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        branch("blt_tk",  4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 4);
        branch("blt_nt",  4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5);
        branch("b",       4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        t_z = 1'b0; t_n = 1'b0; t_v = 1'b0;

        // ADDS: flags update, rd written.
        t_op = 4'd1;
        add("adds_fetch", e_fetch(1'b1, 7));
        add("adds_dec",   e_dec(1'b0, 7));
        add("adds_exec",  e_exec(2'd0, 1'b1, 7));
        add("adds_wb",    e_wb(2'd0, 7));

        // STUR, zero-wait: 4 cycles, retires in MEM.
        t_op = 4'd9;
        add("stur_fetch", e_fetch(1'b1, 8));
        add("stur_dec",   e_dec(1'b0, 8));
        add("stur_exec",  e_exec(2'd2, 1'b0, 8));
        add("stur_mem",   e_mem(1'b1, 1'b1, 8));

        // LSL: shamt operand.
        t_op = 4'd6;
        add("lsl_fetch", e_fetch(1'b1, 9));
        add("lsl_dec",   e_dec(1'b0, 9));
        add("lsl_exec",  e_exec(2'd3, 1'b0, 9));
        add("lsl_wb",    e_wb(2'd0, 9));

        // MUL, done on the 5th wait cycle.
        t_op = 4'd8;
        add("mul_fetch", e_fetch(1'b1, 10));
        add("mul_dec",   e_dec(1'b1, 10));
        for (int i = 0; i < 4; i++) add("mul_wait", e_idle(10));
        t_done = 1'b1;
        add("mul_wait_done", e_idle(10));
        t_done = 1'b0;
        add("mul_wb", e_wb(2'd2, 10));

        // STUR interrupted by reset in MEM.
        t_op = 4'd9;
        add("sturx_fetch", e_fetch(1'b1, 11));
        add("sturx_dec",   e_dec(1'b0, 11));
        add("sturx_exec",  e_exec(2'd2, 1'b0, 11));
        t_rdy = 1'b0;
        add("sturx_mem_wait", e_mem(1'b1, 1'b0, 11));
        t_rst = 1'b1; t_rdy = 1'b1;
        add("sturx_reset", e_zero());
        t_rst = 1'b0; t_rdy = 1'b0;
        add("sturx_refetch_wait", e_fetch(1'b0, 0));

        // INV (11): halt with fault 1, memory ignored afterwards.
        t_rdy = 1'b1; t_op = 4'd11;
        add("inv_fetch", e_fetch(1'b1, 0));
        add("inv_dec",   e_dec(1'b0, 0));
        add("inv_halt0", e_halt(2'd1, 0));
        add("inv_halt1", e_halt(2'd1, 0));
        t_rst = 1'b1;
        add("inv_reset", e_zero());

        // MUL timeout with MUL_TIMEOUT=8.
        t_rst = 1'b0; t_op = 4'd8;
        add("mto_fetch", e_fetch(1'b1, 0));
        add("mto_dec",   e_dec(1'b1, 0));
        for (int i = 0; i < 8; i++) add("mto_wait", e_idle(0));
        add("mto_halt0", e_halt(2'd2, 0));
        t_done = 1'b1;
        add("mto_halt_late_done", e_halt(2'd2, 0));
        t_done = 1'b0; t_rst = 1'b1;
        add("mto_reset", e_zero());

        // Opcode 14 is treated as INV.
        t_rst = 1'b0; t_op = 4'd14;
        add("op14_fetch", e_fetch(1'b1, 0));
        add("op14_dec",   e_dec(1'b0, 0));
        add("op14_halt",  e_halt(2'd1, 0));
        t_rst = 1'b1;
        add("op14_reset", e_zero());

        // Clean restart: ADDI retires once from zero.
        t_rst = 1'b0; t_op = 4'd0;
        add("addi2_fetch", e_fetch(1'b1, 0));
        add("addi2_dec",   e_dec(1'b0, 0));
        add("addi2_exec",  e_exec(2'd1, 1'b0, 0));
        add("addi2_wb",    e_wb(2'd0, 0));
        add("addi2_next",  e_fetch(1'b1, 1));

        // ---------------- apply and compare ----------------
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            flag_n    = vecs[i].n;
            flag_v    = vecs[i].v;
            mem_ready = vecs[i].rdy;
            mul_done  = vecs[i].done;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            got.mem_req   = mem_req;   got.mem_we    = mem_we;
            got.addr_sel  = addr_sel;  got.ir_we     = ir_we;
            got.mdr_we    = mdr_we;    got.alu_b_sel = alu_b_sel;
            got.flags_we  = flags_we;  got.mul_start = mul_start;
            got.reg_we    = reg_we;    got.wb_sel    = wb_sel;
            got.pc_we     = pc_we;     got.pc_src    = pc_src;
            got.halted    = halted;    got.fault     = fault;
            got.retired   = retired;
            exp = sb.pop_front();
            check(vecs[i].name, got, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
